// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and frame checksum for the UART command layer.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_REQ = 8'hA5;
  localparam logic [7:0] SYNC_RSP = 8'h5A;
  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_NAK  = 8'h4E;

  localparam logic [7:0] ERR_NONE = 8'd0;
  localparam logic [7:0] ERR_SYNC = 8'd1;
  localparam logic [7:0] ERR_CS   = 8'd2;
  localparam logic [7:0] ERR_CMD  = 8'd3;
  localparam logic [7:0] ERR_ADDR = 8'd4;

  localparam logic [7:0] ADDR_FREQ   = 8'd0;
  localparam logic [7:0] ADDR_AMP    = 8'd1;
  localparam logic [7:0] ADDR_WAVE   = 8'd2;
  localparam logic [7:0] ADDR_STATUS = 8'd3;

  localparam logic [7:0] VERSION = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SETTLE_FLUSH,
    ST_CHECK,
    ST_TX_REQ,
    ST_TX_WAIT
  } state_t;

  // XOR of bytes 0..6 of an 8-byte frame; byte 7 is the checksum slot itself.
  function automatic logic [7:0] frame_cs(input logic [63:0] f);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 7; k++) c ^= f[8*k +: 8];
    return c;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Validates 8-byte command frames from the UART RX vector, updates the generator
// registers and builds an ACK/NAK reply for the UART transmitter.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int RX_PACKET_SIZE = 64,
  parameter int TX_PACKET_SIZE = 64,
  parameter int TIMEOUT_CYCLES = 43400
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [8*RX_PACKET_SIZE-1:0] rx_bytevect,
  input  logic [15:0]                 rx_size_ready,
  input  logic                        rx_buffer_full,
  input  logic                        tx_done,
  output logic                        rx_reset,
  output logic [8*TX_PACKET_SIZE-1:0] tx_bytevect,
  output logic [15:0]                 tx_size,
  output logic                        tx_go,
  output logic [31:0]                 freq_word,
  output logic [11:0]                 amplitude,
  output logic [1:0]                  waveform,
  output logic                        cfg_update
);

  state_t      state, state_nxt;
  logic [63:0] frame;
  logic [15:0] size_prev;
  logic [31:0] to_cnt;
  logic [7:0]  err_count;
  logic        frame_rdy, partial, to_hit;
  logic        latch_frame, do_flush, do_check, err_inc;
  logic [7:0]  cmd, addr, err_code;
  logic [31:0] data, wr_val, rd_val;
  logic [55:0] body;
  logic [63:0] reply;
  logic        unused_rx;

  assign unused_rx = ^rx_bytevect;

  assign frame_rdy = (rx_size_ready >= 16'd8) || rx_buffer_full;
  assign partial   = (rx_size_ready != 16'd0) && (rx_size_ready < 16'd8);
  assign to_hit    = partial && (rx_size_ready == size_prev) && (to_cnt == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (frame_rdy)   state_nxt = ST_SETTLE;
        else if (to_hit) state_nxt = ST_SETTLE_FLUSH;
      end
      ST_SETTLE:       state_nxt = ST_CHECK;
      ST_SETTLE_FLUSH: state_nxt = ST_IDLE;
      ST_CHECK:        state_nxt = ST_TX_REQ;
      ST_TX_REQ:       if (!tx_done) state_nxt = ST_TX_WAIT;
      ST_TX_WAIT:      if (tx_done)  state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_go       = (state == ST_TX_REQ);
    latch_frame = (state == ST_IDLE) && frame_rdy;
    do_flush    = (state == ST_IDLE) && !frame_rdy && to_hit;
    do_check    = (state == ST_CHECK);
  end

  assign cmd  = frame[15:8];
  assign addr = frame[23:16];
  assign data = frame[55:24];

  always_comb begin
    err_code = ERR_NONE;
    if (frame[7:0] != SYNC_REQ)                       err_code = ERR_SYNC;
    else if (frame_cs(frame) != frame[63:56])         err_code = ERR_CS;
    else if (cmd != CMD_W && cmd != CMD_R)            err_code = ERR_CMD;
    else if (addr > ADDR_STATUS || (cmd == CMD_W && addr == ADDR_STATUS))
                                                      err_code = ERR_ADDR;
  end

  always_comb begin
    wr_val = data;
    case (addr)
      ADDR_AMP:  wr_val = {20'd0, data[11:0]};
      ADDR_WAVE: wr_val = {30'd0, data[1:0]};
      default:   wr_val = data;
    endcase
    rd_val = '0;
    case (addr)
      ADDR_FREQ:   rd_val = freq_word;
      ADDR_AMP:    rd_val = {20'd0, amplitude};
      ADDR_WAVE:   rd_val = {30'd0, waveform};
      ADDR_STATUS: rd_val = {VERSION, 16'h0000, err_count};
      default:     rd_val = '0;
    endcase
    if (err_code != ERR_NONE) body = {24'd0, err_code, addr, CMD_NAK, SYNC_RSP};
    else                      body = {(cmd == CMD_W) ? wr_val : rd_val, addr, cmd, SYNC_RSP};
    reply = {frame_cs({8'd0, body}), body};
  end

  assign err_inc = do_flush || (do_check && err_code != ERR_NONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame       <= '0;
      size_prev   <= '0;
      to_cnt      <= '0;
      err_count   <= '0;
      rx_reset    <= 1'b0;
      tx_bytevect <= '0;
      tx_size     <= '0;
      freq_word   <= '0;
      amplitude   <= 12'h800;
      waveform    <= '0;
      cfg_update  <= 1'b0;
    end else begin
      size_prev  <= rx_size_ready;
      rx_reset   <= latch_frame || do_flush;
      cfg_update <= 1'b0;

      // Counter only advances while a partial frame sits unchanged in IDLE.
      if (state != ST_IDLE || !partial || rx_size_ready != size_prev || do_flush)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 32'd1;

      if (latch_frame) frame <= rx_bytevect[63:0];

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (do_check) begin
        tx_bytevect        <= '0;
        tx_bytevect[63:0]  <= reply;
        tx_size            <= 16'd8;
        if (err_code == ERR_NONE && cmd == CMD_W) begin
          cfg_update <= 1'b1;
          case (addr)
            ADDR_FREQ: freq_word <= data;
            ADDR_AMP:  amplitude <= data[11:0];
            ADDR_WAVE: waveform  <= data[1:0];
            default:   ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of frames plus timeout, back-to-back and reset sequences.
module tb_uart_cmd_parser;

  localparam int T = 200;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] rx_bytevect;
  logic [15:0]  rx_size_ready;
  logic         rx_buffer_full;
  logic         tx_done;
  logic         rx_reset;
  logic [511:0] tx_bytevect;
  logic [15:0]  tx_size;
  logic         tx_go;
  logic [31:0]  freq_word;
  logic [11:0]  amplitude;
  logic [1:0]   waveform;
  logic         cfg_update;

  uart_cmd_parser #(.RX_PACKET_SIZE(64), .TX_PACKET_SIZE(64), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .rx_bytevect(rx_bytevect), .rx_size_ready(rx_size_ready),
    .rx_buffer_full(rx_buffer_full), .tx_done(tx_done), .rx_reset(rx_reset),
    .tx_bytevect(tx_bytevect), .tx_size(tx_size), .tx_go(tx_go), .freq_word(freq_word),
    .amplitude(amplitude), .waveform(waveform), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rr_cnt = 0, cfg_cnt = 0, go_cnt = 0;

  always @(negedge clk) begin
    if (rx_reset)   rr_cnt  <= rr_cnt + 1;
    if (cfg_update) cfg_cnt <= cfg_cnt + 1;
    if (tx_go)      go_cnt  <= go_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fr(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  // Waits for tx_go, emulating the UART clearing its buffer on rx_reset.
  task automatic wait_go(output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (rx_reset) begin
        rx_size_ready  = '0;
        rx_bytevect    = '0;
        rx_buffer_full = 1'b0;
      end
      if (tx_go) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_tx(output logic held, output logic dropped);
    tx_done = 1'b1;
    held = 1'b1;
    repeat (2) begin
      @(negedge clk);
      held = held & tx_go;
    end
    tx_done = 1'b0;
    @(negedge clk);
    dropped = !tx_go;
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic present(input logic [63:0] f, input logic [15:0] n, input logic full);
    @(negedge clk);
    rx_bytevect = '0;
    rx_bytevect[63:0] = f;
    for (int b = 8; b < 64 && b < int'(n); b++) rx_bytevect[8*b +: 8] = 8'hEE;
    rx_size_ready  = n;
    rx_buffer_full = full;
  endtask

  task automatic txn(input string nm, input logic [63:0] f, input logic [15:0] n,
                     input logic full, input logic [63:0] rsp);
    int lat, rr0;
    logic held, dropped;
    rr0 = rr_cnt;
    present(f, n, full);
    wait_go(lat);
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk({nm, "_reply"}, tx_bytevect[63:0], rsp);
    finish_tx(held, dropped);
    chk({nm, "_rxreset"}, 64'(rr_cnt - rr0), 64'd1);
    chk({nm, "_go_held"}, 64'(held), 64'd1);
    chk({nm, "_go_drop"}, 64'(dropped), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [63:0] req;
    logic [15:0] n;
    logic        full;
    logic [63:0] rsp;
    logic [31:0] freq;
    logic [11:0] amp;
    logic [1:0]  wave;
    int          cfg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, rr0, go0, cfg0, elapsed;
    logic held, dropped;

    vecs[0]  = '{"wr_freq",   fr(8'hA5,8'h57,8'h00,8'h78,8'h56,8'h34,8'h12,8'hFA), 16'd8,  1'b0,
                 fr(8'h5A,8'h57,8'h00,8'h78,8'h56,8'h34,8'h12,8'h05), 32'h12345678, 12'h800, 2'd0, 1};
    vecs[1]  = '{"bad_cs",    fr(8'hA5,8'h57,8'h00,8'h78,8'h56,8'h34,8'h12,8'h00), 16'd8,  1'b0,
                 fr(8'h5A,8'h4E,8'h00,8'h02,8'h00,8'h00,8'h00,8'h16), 32'h12345678, 12'h800, 2'd0, 0};
    vecs[2]  = '{"wr_amp",    fr(8'hA5,8'h57,8'h01,8'hFF,8'h0F,8'hFF,8'hFF,8'h03), 16'd8,  1'b0,
                 fr(8'h5A,8'h57,8'h01,8'hFF,8'h0F,8'h00,8'h00,8'hFC), 32'h12345678, 12'hFFF, 2'd0, 1};
    vecs[3]  = '{"rd_status", fr(8'hA5,8'h52,8'h03,8'h00,8'h00,8'h00,8'h00,8'hF4), 16'd8,  1'b0,
                 fr(8'h5A,8'h52,8'h03,8'h01,8'h00,8'h00,8'h01,8'h0B), 32'h12345678, 12'hFFF, 2'd0, 0};
    vecs[4]  = '{"bad_sync",  fr(8'h00,8'h57,8'h00,8'h00,8'h00,8'h00,8'h00,8'h57), 16'd8,  1'b0,
                 fr(8'h5A,8'h4E,8'h00,8'h01,8'h00,8'h00,8'h00,8'h15), 32'h12345678, 12'hFFF, 2'd0, 0};
    vecs[5]  = '{"bad_cmd",   fr(8'hA5,8'h41,8'h00,8'h00,8'h00,8'h00,8'h00,8'hE4), 16'd8,  1'b0,
                 fr(8'h5A,8'h4E,8'h00,8'h03,8'h00,8'h00,8'h00,8'h17), 32'h12345678, 12'hFFF, 2'd0, 0};
    vecs[6]  = '{"wr_status", fr(8'hA5,8'h57,8'h03,8'h01,8'h00,8'h00,8'h00,8'hF0), 16'd8,  1'b0,
                 fr(8'h5A,8'h4E,8'h03,8'h04,8'h00,8'h00,8'h00,8'h13), 32'h12345678, 12'hFFF, 2'd0, 0};
    vecs[7]  = '{"bad_addr",  fr(8'hA5,8'h52,8'h07,8'h00,8'h00,8'h00,8'h00,8'hF0), 16'd8,  1'b0,
                 fr(8'h5A,8'h4E,8'h07,8'h04,8'h00,8'h00,8'h00,8'h17), 32'h12345678, 12'hFFF, 2'd0, 0};
    vecs[8]  = '{"wr_wave",   fr(8'hA5,8'h57,8'h02,8'h07,8'h00,8'h00,8'h00,8'hF7), 16'd8,  1'b0,
                 fr(8'h5A,8'h57,8'h02,8'h03,8'h00,8'h00,8'h00,8'h0C), 32'h12345678, 12'hFFF, 2'd3, 1};
    vecs[9]  = '{"rd_freq_ovr", fr(8'hA5,8'h52,8'h00,8'h00,8'h00,8'h00,8'h00,8'hF7), 16'd11, 1'b0,
                 fr(8'h5A,8'h52,8'h00,8'h78,8'h56,8'h34,8'h12,8'h00), 32'h12345678, 12'hFFF, 2'd3, 0};
    vecs[10] = '{"rd_status_full", fr(8'hA5,8'h52,8'h03,8'h00,8'h00,8'h00,8'h00,8'hF4), 16'd64, 1'b1,
                 fr(8'h5A,8'h52,8'h03,8'h05,8'h00,8'h00,8'h01,8'h0F), 32'h12345678, 12'hFFF, 2'd3, 0};
    vecs[11] = '{"cmd_before_addr", fr(8'hA5,8'h00,8'h09,8'h00,8'h00,8'h00,8'h00,8'hAC), 16'd8, 1'b0,
                 fr(8'h5A,8'h4E,8'h09,8'h03,8'h00,8'h00,8'h00,8'h1E), 32'h12345678, 12'hFFF, 2'd3, 0};

    reset_n = 1'b0;
    rx_bytevect = '0;
    rx_size_ready = '0;
    rx_buffer_full = 1'b0;
    tx_done = 1'b1;
    #12;
    chk("rst_rx_reset", 64'(rx_reset), 64'd0);
    chk("rst_tx_go", 64'(tx_go), 64'd0);
    chk("rst_tx_size", 64'(tx_size), 64'd0);
    chk("rst_tx_vect", 64'(|tx_bytevect), 64'd0);
    chk("rst_cfg", 64'(cfg_update), 64'd0);
    chk("rst_freq", 64'(freq_word), 64'd0);
    chk("rst_amp", 64'(amplitude), 64'h800);
    chk("rst_wave", 64'(waveform), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      cfg0 = cfg_cnt;
      txn(vecs[i].name, vecs[i].req, vecs[i].n, vecs[i].full, vecs[i].rsp);
      chk({vecs[i].name, "_tx_size"}, 64'(tx_size), 64'd8);
      chk({vecs[i].name, "_tx_upper"}, 64'(|tx_bytevect[511:64]), 64'd0);
      chk({vecs[i].name, "_freq"}, 64'(freq_word), 64'(vecs[i].freq));
      chk({vecs[i].name, "_amp"}, 64'(amplitude), 64'(vecs[i].amp));
      chk({vecs[i].name, "_wave"}, 64'(waveform), 64'(vecs[i].wave));
      chk({vecs[i].name, "_cfg"}, 64'(cfg_cnt - cfg0), 64'(vecs[i].cfg));
    end

    // Second frame arrives while the first reply is still being sent.
    present(fr(8'hA5,8'h57,8'h01,8'h23,8'h01,8'h00,8'h00,8'hD1), 16'd8, 1'b0);
    wait_go(lat);
    chk("b2b_first_latency", 64'(lat), 64'd3);
    tx_done = 1'b0;
    @(negedge clk);
    rr0 = rr_cnt;
    present(fr(8'hA5,8'h52,8'h01,8'h00,8'h00,8'h00,8'h00,8'hF6), 16'd8, 1'b0);
    repeat (5) @(negedge clk);
    chk("b2b_held_off", 64'(rr_cnt - rr0), 64'd0);
    chk("b2b_first_reply", tx_bytevect[63:0], fr(8'h5A,8'h57,8'h01,8'h23,8'h01,8'h00,8'h00,8'h2E));
    chk("b2b_amp", 64'(amplitude), 64'h123);
    tx_done = 1'b1;
    wait_go(lat);
    chk("b2b_second_seen", 64'(lat > 0), 64'd1);
    chk("b2b_second_reply", tx_bytevect[63:0], fr(8'h5A,8'h52,8'h01,8'h23,8'h01,8'h00,8'h00,8'h2B));
    finish_tx(held, dropped);
    chk("b2b_second_drop", 64'(dropped), 64'd1);

    // Partial frame: the count changes mid-way, which must restart the timeout.
    rr0 = rr_cnt;
    go0 = go_cnt;
    present(fr(8'hA5,8'h57,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 16'd3, 1'b0);
    repeat (T / 2) @(negedge clk);
    chk("to_no_early_flush", 64'(rr_cnt - rr0), 64'd0);
    rx_size_ready = 16'd4;
    elapsed = -1;
    for (int c = 1; c <= T + 20; c++) begin
      @(negedge clk);
      if (rx_reset) begin
        elapsed = c;
        rx_size_ready = '0;
        rx_bytevect = '0;
        break;
      end
    end
    chk("to_elapsed_in_window", 64'(elapsed >= T && elapsed <= T + 4), 64'd1);
    repeat (20) @(negedge clk);
    chk("to_single_pulse", 64'(rr_cnt - rr0), 64'd1);
    chk("to_no_tx_go", 64'(go_cnt - go0), 64'd0);
    txn("to_status", fr(8'hA5,8'h52,8'h03,8'h00,8'h00,8'h00,8'h00,8'hF4), 16'd8, 1'b0,
        fr(8'h5A,8'h52,8'h03,8'h07,8'h00,8'h00,8'h01,8'h0D));

    // Asynchronous reset while the transmit request is held.
    present(fr(8'hA5,8'h57,8'h00,8'hDD,8'hCC,8'hBB,8'hAA,8'hF2), 16'd8, 1'b0);
    wait_go(lat);
    chk("arst_pre_go", 64'(tx_go), 64'd1);
    chk("arst_pre_freq", 64'(freq_word), 64'hAABBCCDD);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tx_go", 64'(tx_go), 64'd0);
    chk("arst_freq", 64'(freq_word), 64'd0);
    chk("arst_amp", 64'(amplitude), 64'h800);
    chk("arst_wave", 64'(waveform), 64'd0);
    chk("arst_tx_size", 64'(tx_size), 64'd0);
    chk("arst_tx_vect", 64'(|tx_bytevect), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    txn("arst_status", fr(8'hA5,8'h52,8'h03,8'h00,8'h00,8'h00,8'h00,8'hF4), 16'd8, 1'b0,
        fr(8'h5A,8'h52,8'h03,8'h00,8'h00,8'h00,8'h01,8'h0A));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Command layer directly downstream of the UART receiver and upstream of its transmitter. It consumes the UART RX byte vector, validates fixed 8-byte command frames, and updates the function-generator configuration registers.
- It builds an ACK/NAK reply frame into the UART TX byte vector and starts transmission.
- It owns RX buffer clearing: one frame is processed per RX reset, and a stalled partial frame is flushed after a timeout.

Parameters:
RX_PACKET_SIZE, 64, byte capacity of rx_bytevect (must be >= 8)
TX_PACKET_SIZE, 64, byte capacity of tx_bytevect (must be >= 8)
TIMEOUT_CYCLES, 43400, clk cycles a partial frame may sit unchanged before flush (10 byte times at 115200 baud, 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
rx_bytevect  in  8*RX_PACKET_SIZE  received bytes; byte k = bits [8k+7:8k]
rx_size_ready  in  16  count of received bytes
rx_buffer_full  in  1  UART RX buffer full flag
tx_done  in  1  UART transmit complete; high when idle
rx_reset  out  1  active-high RX clear request; the UART edge-detects it
tx_bytevect  out  8*TX_PACKET_SIZE  reply bytes, same byte ordering as rx_bytevect
tx_size  out  16  reply length in bytes
tx_go  out  1  transmit request; the UART edge-detects it
freq_word  out  32  DDS tuning word (register 0)
amplitude  out  12  amplitude code (register 1)
waveform  out  2  waveform select (register 2)
cfg_update  out  1  one-cycle pulse after any successful write

Behaviour:
- Reset values (async, reset_n=0):
  - rx_reset=0, tx_go=0, tx_size=0, tx_bytevect=0, cfg_update=0.
  - freq_word=0, amplitude=12'h800, waveform=0, err_count=0.
  - State=IDLE, timeout counter=0.
  - A reset mid-transmit drops tx_go immediately.
- Request frame, bytes 0..7: A5, cmd, addr, d0..d3 (32-bit little-endian), cs. cs = XOR of bytes 0..6.
- Commands:
  - 0x57 'W': write.
  - 0x52 'R': read.
- Registers:
  - 0: freq_word, R/W.
  - 1: amplitude, R/W; write uses data[11:0], read zero-extends.
  - 2: waveform, R/W; write uses data[1:0].
  - 3: status, read-only = {8'h01 version, 16'h0000, err_count}.
  - Addr >3 is invalid.
- Error precedence: sync!=A5 (code 1) > bad cs (2) > bad cmd (3) > bad addr or write to 3 (4).
- ACK reply: 5A, cmd, addr, register value after the operation (LE), cs. Reply cs follows the same XOR rule.
- NAK reply: 5A, 4E, addr, code, 00, 00, 00, cs.
- tx_size=8 for every reply.
- err_count: 8-bit, saturating at 255. Increments on every NAK and every timeout flush.
- State machine:
  - IDLE:
    - If rx_size_ready>=8 or rx_buffer_full: latch bytes 0..7 into the frame register, drive rx_reset=1, go SETTLE. Bytes beyond 8 are discarded.
    - Else if 0<rx_size_ready<8: the timeout counter runs. It reloads to 0 whenever rx_size_ready changes or is 0. On reaching TIMEOUT_CYCLES: rx_reset=1, err_count+1, go SETTLE_FLUSH.
  - SETTLE / SETTLE_FLUSH: rx_reset=0 for one cycle so the UART zeroes its count. SETTLE goes to CHECK; SETTLE_FLUSH goes to IDLE.
  - CHECK (1 cycle):
    - Classify the frame and perform the write if valid; cfg_update pulses in the following cycle.
    - Load tx_bytevect[63:0] and tx_size. Upper TX bytes are 0.
    - Go TX_REQ.
  - TX_REQ: tx_go=1. Hold until tx_done=0 is sampled, then go TX_WAIT.
  - TX_WAIT: tx_go=0. When tx_done=1, go IDLE.
- Frame-in to tx_go latency: 3 cycles (IDLE, SETTLE, CHECK). tx_go rises in the 4th.
- Bytes of a new frame arriving during TX_REQ/TX_WAIT accumulate in the UART and are processed on return to IDLE.
- A read of status in the same frame as an error is impossible; NAK is sent instead.

Decomposition:
- Shared package/header uart_cmd_pkg holds:
  - Constants SYNC_REQ=8'hA5, SYNC_RSP=8'h5A, CMD_W, CMD_R, CMD_NAK=8'h4E.
  - Error codes 1-4, register addresses 0-3, VERSION=8'h01.
  - State encoding.
  - 8-byte XOR checksum function.
- No sub-module: the checksum function plus an inline register file keep the block at ~200 lines.

Test Plan:
- Write freq: frame A5 57 00 78 56 34 12 FA -> rx_reset pulse, freq_word=32'h12345678, cfg_update 1 pulse, tx_bytevect[63:0]= 5A 57 00 78 56 34 12 05, tx_size=8, tx_go held until tx_done falls.
- Bad checksum: A5 57 00 78 56 34 12 00 -> NAK 5A 4E 00 02 00 00 00 16, freq_word unchanged, err_count=1, no cfg_update.
- Masking/readback: write addr 1 data FFFF0FFF (valid cs) -> amplitude=12'hFFF, ACK data 00000FFF. Then R addr 3 -> data {01,00,00,err_count}.
- Timeout: 3 bytes then silence for TIMEOUT_CYCLES+2 -> single rx_reset pulse, no tx_go, err_count+1. Then a valid frame is processed normally.
- Overrun/back-to-back: rx_size_ready=11 (frame + 3 extra) -> first 8 bytes processed, extra bytes dropped. A second frame arriving during TX_WAIT -> second reply after tx_done rises.
- Async reset asserted in TX_REQ -> tx_go=0 same instant, all registers return to reset values (amplitude=800), state IDLE after release.
